ibus_axi_rom_slave: RTL and testbench

AXI4 read-only responder serving the instruction-side read bursts that the Icache issues on `axi_ibus`, both cached line refills and uncached single-word fetches. It holds a word-addressed instruction memory that a backdoor load port fills, and it returns INCR, WRAP and FIXED bursts with full `rready` backpressure. It is the memory end of the fetch path, for simulation and FPGA boot-ROM builds.

---
 rtl/ibus_axi_rom_slave.sv | 198 +++++++++++++++++++
 tb/tb_ibus_axi_rom_slave.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_axi_rom_slave.sv
// AXI4 read-only instruction memory responder: one outstanding burst, FIXED/INCR/WRAP,
// per-beat SLVERR on illegal requests or out-of-range beats, backdoor load port.
module ibus_axi_rom_slave #(
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h1fc0_0000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic                load_en,
  input  logic [31:0]         load_addr,
  input  logic [31:0]         load_data,
  output logic                busy
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]          state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d;
  logic [7:0]          beat_q, beat_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                busy_q, busy_d;

  logic        ar_err;
  logic [7:0]  nxt_beat;
  logic [31:0] nxt_addr;
  logic [31:0] nxt_rel;
  logic        nxt_err;
  logic [31:0] nxt_data;
  logic [31:0] load_rel;

  // Byte address of beat n; the WRAP mask (len+1)*4-1 is simply {len, 2'b11}.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [1:0] burst, input logic [7:0] n);
    logic [31:0] incr;
    logic [31:0] mask;
    incr = a + {22'd0, n, 2'b00};
    mask = {22'd0, len, 2'b11};
    case (burst)
      BURST_FIXED: beat_addr = a;
      BURST_WRAP:  beat_addr = (a & ~mask) | (incr & mask);
      default:     beat_addr = incr;
    endcase
  endfunction

  assign ar_err = (arsize != 3'b010) || (araddr[1:0] != 2'b00) || (arburst == BURST_RSVD) ||
                  ((arburst == BURST_WRAP) && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // Next beat to present: beat 0 out of FETCH, otherwise the one after the current beat.
  assign nxt_beat = (state_q == S_FETCH) ? 8'd0 : beat_q + 8'd1;
  assign nxt_addr = beat_addr(addr_q, len_q, burst_q, nxt_beat);
  assign nxt_rel  = nxt_addr - BASE_ADDR;
  assign nxt_err  = err_q || (nxt_rel >= MEM_BYTES);
  assign nxt_data = mem[AW'(nxt_rel >> 2)];
  assign load_rel = load_addr - BASE_ADDR;

  // Backdoor write; the registered read above sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (load_en && (load_rel < MEM_BYTES)) begin
      mem[AW'(load_rel >> 2)] <= load_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    err_d     = err_q;
    beat_d    = beat_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          arready_d = 1'b0;
          rid_d     = arid;
          addr_d    = araddr;
          len_d     = arlen;
          burst_d   = arburst;
          err_d     = ar_err;
          beat_d    = 8'd0;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        beat_d   = nxt_beat;
        rvalid_d = 1'b1;
        rlast_d  = (len_q == 8'd0);
        rdata_d  = nxt_err ? 32'd0 : nxt_data;
        rresp_d  = nxt_err ? RESP_SLVERR : RESP_OKAY;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            beat_d  = nxt_beat;
            rlast_d = (nxt_beat == len_q);
            rdata_d = nxt_err ? 32'd0 : nxt_data;
            rresp_d = nxt_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      len_q     <= 8'd0;
      burst_q   <= 2'd0;
      err_q     <= 1'b0;
      beat_q    <= 8'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= 32'd0;
      rresp_q   <= 2'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      busy_q    <= busy_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ibus_axi_rom_slave.sv
// Self-checking bench for ibus_axi_rom_slave: directed scenarios plus random bursts
// checked against an array-based memory model and arithmetic beat-address rules.
module tb_ibus_axi_rom_slave;

  localparam int unsigned IDW   = 4;
  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h1fc0_0000;
  localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

  logic           clk = 1'b0;
  logic           resetn;
  logic [IDW-1:0] arid;
  logic [31:0]    araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid;
  logic           arready;
  logic [IDW-1:0] rid;
  logic [31:0]    rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           rvalid;
  logic           rready;
  logic           load_en;
  logic [31:0]    load_addr;
  logic [31:0]    load_data;
  logic           busy;

  ibus_axi_rom_slave #(.ID_WIDTH(IDW), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [DEPTH];

  logic [31:0]    g_data[$];
  logic [1:0]     g_resp[$];
  logic           g_last[$];
  logic [IDW-1:0] g_id[$];
  int             g_first_lat;
  int             g_hold_bad;
  int             g_overlap;
  int             g_ar_wait;
  bit             g_timeout;
  logic           g_ar_after;
  logic           g_rv_after;
  bit             rr_pat[$];
  int             coll_edge = 0;
  logic [31:0]    coll_addr;
  logic [31:0]    coll_data;

  // Reference: beat n of a burst from plain address arithmetic over the model array.
  function automatic void exp_beat(input logic [31:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst, input int n,
                                   output logic [31:0] d, output logic [1:0] r);
    longint unsigned a, w, base64;
    bit err;
    err = (size != 3'd2) || ((addr % 4) != 0) || (burst == 2'd3) ||
          (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    w = (64'(len) + 64'd1) * 64'd4;
    base64 = 64'(BASE);
    if (burst == 2'd0) a = 64'(addr);
    else if (burst == 2'd1) a = (64'(addr) + 64'(4 * n)) % 64'h1_0000_0000;
    else a = (64'(addr) / w) * w + ((64'(addr) + 64'(4 * n)) % w);
    if (!err && a >= base64 && a < base64 + 64'(4 * DEPTH)) begin
      d = model[int'((a - base64) / 64'd4)];
      r = 2'b00;
    end else begin
      d = 32'd0;
      r = 2'b10;
    end
  endfunction

  // Drives one AR and collects R beats; mode 0: rready=1, 1: rr_pat, 2: random.
  task automatic run_burst(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    int cyc, edge_n, pidx;
    logic [31:0] hd;
    logic [1:0] hr;
    logic hl;
    logic [IDW-1:0] hi;
    bit holding, done;
    g_data.delete(); g_resp.delete(); g_last.delete(); g_id.delete();
    g_first_lat = -1; g_hold_bad = 0; g_overlap = 0; g_timeout = 0; g_ar_wait = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    g_ar_wait = cyc;
    if (!arready) begin
      g_timeout = 1; arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    edge_n = 0; pidx = 0; holding = 0; done = 0;
    while (!done && cyc < 2000 && g_data.size() < 300) begin
      if (g_first_lat < 0 && rvalid) g_first_lat = edge_n;
      if (rvalid && arready) g_overlap++;
      if (holding && (!rvalid || rdata !== hd || rresp !== hr || rlast !== hl || rid !== hi))
        g_hold_bad++;
      holding = 0;
      if (mode == 0) rready = 1'b1;
      else if (mode == 1) begin
        rready = rvalid ? rr_pat[pidx % rr_pat.size()] : 1'b0;
        if (rvalid) pidx++;
      end else rready = 1'($urandom_range(0, 1));
      load_en   = (coll_edge != 0 && edge_n + 1 == coll_edge);
      load_addr = coll_addr;
      load_data = coll_data;
      if (rvalid && rready) begin
        g_data.push_back(rdata); g_resp.push_back(rresp);
        g_last.push_back(rlast); g_id.push_back(rid);
        if (rlast) done = 1;
      end else if (rvalid) begin
        holding = 1; hd = rdata; hr = rresp; hl = rlast; hi = rid;
      end
      @(posedge clk); #1;
      edge_n++; cyc++;
    end
    load_en = 1'b0; rready = 1'b0;
    if (!done) g_timeout = 1;
    g_ar_after = arready;
    g_rv_after = rvalid;
  endtask

  task automatic test_reset();
    resetn = 1'b1; arvalid = 1'b0; rready = 1'b0; load_en = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1;
    load_addr = '0; load_data = '0;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({arready, rvalid, rlast, busy} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got arready/rvalid/rlast/busy=%b required=0000", {arready, rvalid, rlast, busy});
    end
    total++;
    if (rid !== '0 || rdata !== 32'd0 || rresp !== 2'd0) begin
      bad++; $display("FAIL reset_data got rid=%h rdata=%h rresp=%b required zeros", rid, rdata, rresp);
    end
    @(negedge clk) resetn = 1'b1;
    #1;
    total++;
    if (arready !== 1'b0) begin bad++; $display("FAIL reset_release_early got arready=%b required=0", arready); end
    @(posedge clk); #1;
    total++;
    if (arready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_first_edge got arready=%b busy=%b required 1/0", arready, busy);
    end
  endtask

  task automatic preload_all();
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_en = 1'b1;
      load_addr = BASE + 32'(4 * i) + 32'($urandom_range(0, 3));
      load_data = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom;
      model[i] = load_data;
      @(posedge clk); #1;
    end
    load_en = 1'b0;
  endtask

  task automatic test_incr_fill();
    int nlast;
    run_burst(4'h5, BASE, 8'd7, 3'd2, 2'b01, 0);
    total++;
    if (g_timeout || g_data.size() != 8) begin
      bad++; $display("FAIL fill_count got beats=%0d timeout=%0d required=8", g_data.size(), g_timeout);
    end
    total++;
    if (g_first_lat != 1) begin bad++; $display("FAIL fill_latency got=%0d required=1", g_first_lat); end
    nlast = 0;
    for (int i = 0; i < g_data.size(); i++) begin
      total++;
      if (g_data[i] !== 32'h1000_0000 + 32'(i) || g_resp[i] !== 2'b00 || g_id[i] !== 4'h5 ||
          g_last[i] !== (i == 7)) begin
        bad++; $display("FAIL fill_beat%0d got data=%h resp=%b id=%h last=%b required data=%h okay id=5",
                        i, g_data[i], g_resp[i], g_id[i], g_last[i], 32'h1000_0000 + 32'(i));
      end
    end
    total++;
    if (g_ar_after !== 1'b1 || g_rv_after !== 1'b0 || g_overlap != 0) begin
      bad++; $display("FAIL fill_end got arready=%b rvalid=%b overlap=%0d required 1/0/0", g_ar_after, g_rv_after, g_overlap);
    end
  endtask

  task automatic test_wrap();
    int ord[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    run_burst(4'h9, BASE + 32'h14, 8'd7, 3'd2, 2'b10, 0);
    total++;
    if (g_timeout || g_data.size() != 8) begin
      bad++; $display("FAIL wrap_count got beats=%0d required=8", g_data.size());
    end
    for (int i = 0; i < g_data.size() && i < 8; i++) begin
      total++;
      if (g_data[i] !== 32'h1000_0000 + 32'(ord[i]) || g_resp[i] !== 2'b00) begin
        bad++; $display("FAIL wrap_beat%0d got data=%h resp=%b required data=%h", i, g_data[i], g_resp[i], 32'h1000_0000 + 32'(ord[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [1:0] r;
    rr_pat = '{1, 0, 0, 1, 1, 0, 1};
    run_burst(4'h3, BASE + 32'h40, 8'd3, 3'd2, 2'b01, 1);
    total++;
    if (g_timeout || g_data.size() != 4) begin
      bad++; $display("FAIL bp_count got beats=%0d required=4", g_data.size());
    end
    total++;
    if (g_hold_bad != 0) begin bad++; $display("FAIL bp_hold got unstable=%0d required=0", g_hold_bad); end
    for (int i = 0; i < g_data.size() && i < 4; i++) begin
      exp_beat(BASE + 32'h40, 8'd3, 3'd2, 2'b01, i, d, r);
      total++;
      if (g_data[i] !== d || g_resp[i] !== r) begin
        bad++; $display("FAIL bp_beat%0d got data=%h required=%h", i, g_data[i], d);
      end
    end
    total++;
    if (g_ar_after !== 1'b1) begin bad++; $display("FAIL bp_arready got=%b required=1", g_ar_after); end
  endtask

  task automatic test_errors();
    logic [1:0] eb[4] = '{2'b00, 2'b00, 2'b10, 2'b10};
    run_burst(4'h1, TOP, 8'd0, 3'd2, 2'b01, 0);
    total++;
    if (g_data.size() != 1 || g_resp[0] !== 2'b10 || g_data[0] !== 32'd0 || g_last[0] !== 1'b1) begin
      bad++; $display("FAIL err_single got beats=%0d resp=%b data=%h required 1 beat SLVERR 0 last",
                      g_data.size(), g_resp[0], g_data[0]);
    end
    run_burst(4'h2, TOP - 32'd8, 8'd3, 3'd2, 2'b01, 2);
    total++;
    if (g_data.size() != 4) begin bad++; $display("FAIL err_cross_count got=%0d required=4", g_data.size()); end
    for (int i = 0; i < g_data.size() && i < 4; i++) begin
      total++;
      if (g_resp[i] !== eb[i] || (i < 2 && g_data[i] !== model[int'(DEPTH) - 2 + i]) || (i >= 2 && g_data[i] !== 0)) begin
        bad++; $display("FAIL err_cross_beat%0d got resp=%b data=%h required resp=%b", i, g_resp[i], g_data[i], eb[i]);
      end
    end
    run_burst(4'h4, BASE, 8'd3, 3'd3, 2'b01, 0);
    total++;
    if (g_data.size() != 4) begin bad++; $display("FAIL err_size_count got=%0d required=4", g_data.size()); end
    for (int i = 0; i < g_data.size(); i++) begin
      total++;
      if (g_resp[i] !== 2'b10 || g_data[i] !== 32'd0) begin
        bad++; $display("FAIL err_size_beat%0d got resp=%b data=%h required SLVERR 0", i, g_resp[i], g_data[i]);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] old3, new3;
    old3 = model[3];
    new3 = $urandom;
    coll_edge = 4; coll_addr = BASE + 32'd12; coll_data = new3;
    run_burst(4'h6, BASE, 8'd7, 3'd2, 2'b01, 0);
    coll_edge = 0;
    model[3] = new3;
    total++;
    if (g_data.size() != 8 || g_data[3] !== old3) begin
      bad++; $display("FAIL coll_old got=%h required=%h", g_data[3], old3);
    end
    run_burst(4'h6, BASE, 8'd7, 3'd2, 2'b01, 0);
    total++;
    if (g_data.size() != 8 || g_data[3] !== new3) begin
      bad++; $display("FAIL coll_new got=%h required=%h", g_data[3], new3);
    end
  endtask

  task automatic test_load_range();
    logic [31:0] d;
    logic [1:0] r;
    load_en = 1'b1; load_addr = TOP; load_data = ~model[0];
    @(posedge clk); #1;
    load_addr = BASE - 32'd4; load_data = ~model[DEPTH-1];
    @(posedge clk); #1;
    load_en = 1'b0;
    run_burst(4'h7, BASE, 8'd0, 3'd2, 2'b01, 0);
    total++;
    if (g_data.size() != 1 || g_data[0] !== model[0]) begin
      bad++; $display("FAIL load_oor_high got=%h required=%h", g_data[0], model[0]);
    end
    run_burst(4'h7, TOP - 32'd4, 8'd0, 3'd2, 2'b01, 0);
    total++;
    if (g_data.size() != 1 || g_data[0] !== model[DEPTH-1]) begin
      bad++; $display("FAIL load_oor_low got=%h required=%h", g_data[0], model[DEPTH-1]);
    end
    run_burst(4'h8, BASE + 32'h20, 8'd3, 3'd2, 2'b00, 0);
    for (int i = 0; i < g_data.size(); i++) begin
      exp_beat(BASE + 32'h20, 8'd3, 3'd2, 2'b00, i, d, r);
      total++;
      if (g_data[i] !== d || g_resp[i] !== r) begin
        bad++; $display("FAIL fixed_beat%0d got=%h required=%h", i, g_data[i], d);
      end
    end
    run_burst(4'h8, BASE, 8'd2, 3'd2, 2'b10, 0);
    total++;
    if (g_data.size() != 3 || g_resp[0] !== 2'b10 || g_resp[2] !== 2'b10) begin
      bad++; $display("FAIL wrap_badlen got beats=%0d resp0=%b required 3 SLVERR", g_data.size(), g_resp[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_burst(4'ha, BASE + 32'h80, 8'd1, 3'd2, 2'b01, 0);
    run_burst(4'hb, BASE + 32'h90, 8'd1, 3'd2, 2'b01, 0);
    total++;
    if (g_ar_wait != 0 || g_data.size() != 2 || g_data[1] !== model[37]) begin
      bad++; $display("FAIL b2b got arwait=%0d beats=%0d data1=%h required 0/2/%h", g_ar_wait, g_data.size(), g_data[1], model[37]);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, d;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst, r;
    logic [IDW-1:0] id;
    int woff;
    for (int t = 0; t < 40; t++) begin
      id = IDW'($urandom);
      burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (burst == 2'b10) begin
        case ($urandom_range(0, 4))
          0: len = 8'd1; 1: len = 8'd3; 2: len = 8'd7; 3: len = 8'd15; default: len = 8'($urandom_range(0, 20));
        endcase
      end else len = 8'($urandom_range(0, 24));
      woff = int'($urandom_range(0, DEPTH + 8)) - 4;
      addr = BASE + 32'(4 * woff);
      if ($urandom_range(0, 9) == 0) addr = addr + 32'($urandom_range(1, 3));
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
      run_burst(id, addr, len, size, burst, 2);
      total++;
      if (g_timeout || g_data.size() != int'(len) + 1) begin
        bad++; $display("FAIL rnd%0d_count got=%0d required=%0d", t, g_data.size(), int'(len) + 1);
      end
      for (int i = 0; i < g_data.size() && i <= int'(len); i++) begin
        exp_beat(addr, len, size, burst, i, d, r);
        total++;
        if (g_data[i] !== d || g_resp[i] !== r || g_id[i] !== id || g_last[i] !== (i == int'(len))) begin
          bad++; $display("FAIL rnd%0d_beat%0d got data=%h resp=%b id=%h last=%b required data=%h resp=%b id=%h",
                          t, i, g_data[i], g_resp[i], g_id[i], g_last[i], d, r, id);
        end
      end
      total++;
      if (g_hold_bad != 0 || g_overlap != 0 || g_ar_after !== 1'b1) begin
        bad++; $display("FAIL rnd%0d_proto got unstable=%0d overlap=%0d arready=%b required 0/0/1", t, g_hold_bad, g_overlap, g_ar_after);
      end
    end
  endtask

  task automatic test_reset_midburst();
    logic [31:0] d;
    logic [1:0] r;
    int cyc;
    arid = 4'hc; araddr = BASE + 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rvalid !== 1'b1 || rdata !== model[66]) begin
      bad++; $display("FAIL rstmid_beat2 got rvalid=%b data=%h required 1/%h", rvalid, rdata, model[66]);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({rvalid, rlast, arready, busy} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_async got rvalid/rlast/arready/busy=%b required=0000", {rvalid, rlast, arready, busy});
    end
    rready = 1'b0;
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (arready !== 1'b1) begin bad++; $display("FAIL rstmid_arready got=%b required=1", arready); end
    run_burst(4'hd, BASE + 32'h200, 8'd3, 3'd2, 2'b01, 0);
    total++;
    if (g_data.size() != 4) begin bad++; $display("FAIL rstmid_after_count got=%0d required=4", g_data.size()); end
    for (int i = 0; i < g_data.size(); i++) begin
      exp_beat(BASE + 32'h200, 8'd3, 3'd2, 2'b01, i, d, r);
      total++;
      if (g_data[i] !== d || g_resp[i] !== r) begin
        bad++; $display("FAIL rstmid_after_beat%0d got=%h required=%h", i, g_data[i], d);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    preload_all();
    test_incr_fill();
    test_wrap();
    test_backpressure();
    test_errors();
    test_collision();
    test_load_range();
    test_back_to_back();
    test_random();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
